key_led_ctrl: RTL and testbench



---
 rtl/key_led_pkg.sv | 30 +++
 rtl/key_led_ctrl_debounce.sv | 70 +++++++
 rtl/key_led_ctrl.sv | 92 +++++++++
 tb/tb_key_led_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared definitions for the key-to-LED controller: channel mode encoding
// and the per-channel LED selection rule.
package key_led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIRECT     = 2'b00;
    localparam mode_t MODE_TOGGLE     = 2'b01;
    localparam mode_t MODE_BLINK      = 2'b10;
    localparam mode_t MODE_HOLD_BLINK = 2'b11;

    // LED-on decision for one channel, before output polarity is applied.
    function automatic logic led_sel(input mode_t m, input logic db,
                                     input logic tf, input logic phase);
        logic on;
        case (m)
            MODE_DIRECT: on = db;
            MODE_TOGGLE: on = tf;
            MODE_BLINK:  on = tf & phase;
            default:     on = db & phase;
        endcase
        return on;
    endfunction

    // Only modes that use the toggle flag let a press invert it.
    function automatic logic mode_uses_tf(input mode_t m);
        return (m == MODE_TOGGLE) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// One key channel: two-flop synchroniser, stability counter and a
// registered single-cycle pulse on each accepted press.
module key_debounce #(
    parameter int DB_CYCLES      = 1000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_key,
    output logic o_db,
    output logic o_press
);

    localparam int                 CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);
    // Pin level when the key is not pressed; the synchroniser rests here.
    localparam logic               RELEASED = logic'(KEY_ACTIVE_LOW);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample;

    // Normalise so that 1 always means pressed.
    assign w_sample = r_sync2 ^ RELEASED;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= RELEASED;
            r_sync2 <= RELEASED;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DB_CYCLES cycles.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (w_sample == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_db  <= w_sample;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pulse one cycle after the debounced level rises; releases are silent.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    assign o_db    = r_db;
    assign o_press = r_press;

endmodule

// File: rtl/key_led_ctrl.sv
// Multi-channel key-to-LED controller: per-channel debounce, toggle flag and
// mode-selected LED drive, with one blink timer shared by all channels.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DB_CYCLES       = 1000000,
    parameter int BLINK_HALF      = 12500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_CH-1:0]     key,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led,
    output logic [NUM_CH-1:0]     key_press
);

    localparam int              BL_W    = $clog2(BLINK_HALF);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);
    // XOR mask that turns "lit" into the pin level.
    localparam logic [NUM_CH-1:0] LED_INV = {NUM_CH{~logic'(LED_ACTIVE_HIGH)}};

    logic [NUM_CH-1:0] w_db;
    logic [NUM_CH-1:0] w_press;
    logic [NUM_CH-1:0] w_led_on;
    logic [NUM_CH-1:0] r_tf;
    logic [NUM_CH-1:0] r_led;
    logic [BL_W-1:0]   r_blink_cnt;
    logic              r_phase;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        key_debounce #(
            .DB_CYCLES      (DB_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_db (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .i_key   (key[g]),
            .o_db    (w_db[g]),
            .o_press (w_press[g])
        );
    end

    // Free-running blink timer; phase flips on every wrap (0 = dark).
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Toggle flags invert on a press only in toggle/blink modes, else hold.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_press[i] && mode_uses_tf(mode[2*i +: 2])) begin
                    r_tf[i] <= ~r_tf[i];
                end
            end
        end
    end

    // Per-channel LED selection by mode.
    always_comb begin
        w_led_on = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_led_on[i] = led_sel(mode[2*i +: 2], w_db[i], r_tf[i], r_phase);
        end
    end

    // Register the LED pins with polarity applied; reset shows unlit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_led <= LED_INV;
        end else begin
            r_led <= w_led_on ^ LED_INV;
        end
    end

    assign led       = r_led;
    assign key_press = w_press;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench for key_led_ctrl with two channels, short debounce and
// blink periods, active-low keys and active-high LEDs.
module tb_key_led_ctrl;

    localparam int NUM_CH = 2;
    localparam int DB     = 8;
    localparam int BH     = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [NUM_CH-1:0] key     = 2'b11;
    logic [3:0]        mode    = 4'b0000;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] key_press;

    key_led_ctrl #(
        .NUM_CH          (NUM_CH),
        .DB_CYCLES       (DB),
        .BLINK_HALF      (BH),
        .KEY_ACTIVE_LOW  (1'b1),
        .LED_ACTIVE_HIGH (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key       (key),
        .mode      (mode),
        .led       (led),
        .key_press (key_press)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int pc0   = 0;
    int pc1   = 0;

    // Expected {led, key_press} after each clock edge.
    logic [3:0] exp_q[$];

    // Reference state: pipeline behaviour described cycle by cycle.
    logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_db = 2'b00, m_dbd = 2'b00;
    logic [1:0] m_press = 2'b00, m_tf = 2'b00, m_led = 2'b00;
    int         m_run[2] = '{0, 0};
    int         m_bc = 0;
    logic       m_ph = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] n_db, n_press, n_tf, n_led;
        logic       smp;
        logic [1:0] md;
        int         n_run;
        if (sys_rst) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_db = '0; m_dbd = '0;
            m_press = '0; m_tf = '0; m_led = '0;
            m_run[0] = 0; m_run[1] = 0; m_bc = 0; m_ph = 1'b0;
        end else begin
            n_db = m_db;
            for (int i = 0; i < 2; i++) begin
                md  = mode[2*i +: 2];
                smp = ~m_s2[i];
                n_run = (smp != m_db[i]) ? m_run[i] + 1 : 0;
                if (n_run == DB) begin
                    n_db[i] = smp;
                    n_run = 0;
                end
                m_run[i] = n_run;
                n_press[i] = m_db[i] & ~m_dbd[i];
                n_tf[i] = m_tf[i] ^ (m_press[i] & (md == 2'b01 || md == 2'b10));
                case (md)
                    2'b00:   n_led[i] = m_db[i];
                    2'b01:   n_led[i] = m_tf[i];
                    2'b10:   n_led[i] = m_tf[i] & m_ph;
                    default: n_led[i] = m_db[i] & m_ph;
                endcase
            end
            m_dbd = m_db; m_db = n_db; m_press = n_press; m_tf = n_tf; m_led = n_led;
            m_s2 = m_s1; m_s1 = key;
            if (m_bc == BH - 1) begin
                m_bc = 0;
                m_ph = ~m_ph;
            end else begin
                m_bc = m_bc + 1;
            end
        end
        exp_q.push_back({m_led, m_press});
    endtask

    task automatic step();
        logic [3:0] e;
        model_step();
        @(posedge sys_clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("out", {led, key_press}, e);
        end
        if (key_press[0]) pc0++;
        if (key_press[1]) pc1++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int first;
        int p0;
        int n;
        logic prev;

        // Reset with keys released.
        sys_rst = 1'b1; key = 2'b11; mode = 4'b0000;
        steps(3);
        chk("rst_led", led, 2'b00);
        chk("rst_press", key_press, 2'b00);
        sys_rst = 1'b0;
        steps(4);
        chk("post_rst_led", led, 2'b00);

        // Short glitch is ignored in direct mode.
        key[0] = 1'b0; steps(5);
        key[0] = 1'b1; steps(20);
        chk("glitch_nopress", pc0, 0);
        chk("glitch_led", led[0], 1'b0);

        // Held press: one pulse, 11 cycles after the pin falls.
        key[0] = 1'b0; first = 0; p0 = pc0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (key_press[0] && first == 0) first = k;
        end
        chk("press_lat", first, 11);
        chk("press_cnt", pc0 - p0, 1);
        chk("direct_on", led[0], 1'b1);
        key[0] = 1'b1; steps(20);
        chk("direct_off", led[0], 1'b0);
        chk("no_rel_pulse", pc0 - p0, 1);

        // Toggle on channel 1, two clean presses.
        mode = 4'b0100;
        key[1] = 1'b0; steps(14); key[1] = 1'b1; steps(14);
        chk("tog_on", led[1], 1'b1);
        chk("tog_ch0", led[0], 1'b0);
        key[1] = 1'b0; steps(14); key[1] = 1'b1; steps(14);
        chk("tog_off", led[1], 1'b0);
        chk("tog_cnt", pc1, 2);

        // Latched blink on channel 0.
        mode = 4'b0110;
        key[0] = 1'b0; steps(14); key[0] = 1'b1; steps(14);
        prev = led[0]; n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led[0] != prev) n++;
            prev = led[0];
        end
        chk("blink_edges", n, 4);
        key[0] = 1'b0; steps(14); key[0] = 1'b1; steps(3);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led[0]) n++;
        end
        chk("blink_off", n, 0);

        // Hold-blink: lit only while pressed, flag untouched.
        mode = 4'b0111;
        key[0] = 1'b0; steps(12);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led[0]) n++;
        end
        chk("hb_lit", n, 8);
        key[0] = 1'b1; steps(14);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (led[0]) n++;
        end
        chk("hb_dark", n, 0);
        mode = 4'b0101; step(); step();
        chk("hb_tf_kept", led[0], 1'b0);

        // Blinking, then reset with the key held down.
        mode = 4'b0110;
        key[0] = 1'b0; steps(14); key[0] = 1'b1; steps(14);
        key[0] = 1'b0; steps(3);
        sys_rst = 1'b1; step();
        chk("rst_mid_led", led, 2'b00);
        chk("rst_mid_press", key_press, 2'b00);
        sys_rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (key_press[0] && first == 0) first = k;
        end
        chk("rst_repress", (first >= 10 && first <= 11), 1'b1);
        key[0] = 1'b1; steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
